// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage: memctrl handshake, stall request, load extension
module mem_stage #(
  parameter int OPT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [OPT_W-1:0] in_inst,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_vd,
  input  logic             in_w_enable,
  input  logic [31:0]      in_addr,
  output logic             memctrl_req,
  output logic             memctrl_we,
  output logic [31:0]      memctrl_addr,
  output logic [2:0]       memctrl_len,
  output logic [31:0]      memctrl_wdata,
  input  logic             memctrl_done,
  input  logic [31:0]      memctrl_rdata,
  output logic             stall_req,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_vd,
  output logic             wb_w_enable
);

  localparam logic [OPT_W-1:0] OP_LB  = OPT_W'(10);
  localparam logic [OPT_W-1:0] OP_LH  = OPT_W'(11);
  localparam logic [OPT_W-1:0] OP_LW  = OPT_W'(12);
  localparam logic [OPT_W-1:0] OP_LBU = OPT_W'(13);
  localparam logic [OPT_W-1:0] OP_LHU = OPT_W'(14);
  localparam logic [OPT_W-1:0] OP_SB  = OPT_W'(15);
  localparam logic [OPT_W-1:0] OP_SH  = OPT_W'(16);
  localparam logic [OPT_W-1:0] OP_SW  = OPT_W'(17);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_load;
  logic        is_store;
  logic        memop;
  logic [2:0]  acc_len;
  logic [31:0] load_val;
  logic        req_raw;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    acc_len  = 3'd0;
    case (in_inst)
      OP_LB, OP_LBU: begin is_load  = 1'b1; acc_len = 3'd1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; acc_len = 3'd2; end
      OP_LW:         begin is_load  = 1'b1; acc_len = 3'd4; end
      OP_SB:         begin is_store = 1'b1; acc_len = 3'd1; end
      OP_SH:         begin is_store = 1'b1; acc_len = 3'd2; end
      OP_SW:         begin is_store = 1'b1; acc_len = 3'd4; end
      default: ;
    endcase
    memop = is_load | is_store;
  end

  // done is only honoured in WAIT; a pulse in IDLE or DONE is a protocol violation
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    if (rst) begin
      state_d = S_IDLE;
      rdata_d = 32'd0;
    end else if (rdy) begin
      case (state_q)
        S_IDLE: if (memop) state_d = S_WAIT;
        S_WAIT: begin
          if (memctrl_done) begin
            state_d = S_DONE;
            rdata_d = memctrl_rdata;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    rdata_q <= rdata_d;
  end

  always_comb begin
    load_val = rdata_q;
    case (in_inst)
      OP_LB:   load_val = {{24{rdata_q[7]}}, rdata_q[7:0]};
      OP_LBU:  load_val = {24'd0, rdata_q[7:0]};
      OP_LH:   load_val = {{16{rdata_q[15]}}, rdata_q[15:0]};
      OP_LHU:  load_val = {16'd0, rdata_q[15:0]};
      default: load_val = rdata_q;
    endcase
  end

  assign req_raw = ((state_q == S_IDLE) && memop) || (state_q == S_WAIT);

  // everything is forced low while rst is high, including the request
  always_comb begin
    memctrl_req   = 1'b0;
    memctrl_we    = 1'b0;
    memctrl_addr  = 32'd0;
    memctrl_len   = 3'd0;
    memctrl_wdata = 32'd0;
    stall_req     = 1'b0;
    wb_rd         = 5'd0;
    wb_vd         = 32'd0;
    wb_w_enable   = 1'b0;
    if (!rst) begin
      if (req_raw) begin
        memctrl_req   = 1'b1;
        memctrl_we    = is_store;
        memctrl_addr  = in_addr;
        memctrl_len   = acc_len;
        memctrl_wdata = in_vd;
      end
      stall_req = memop && (state_q != S_DONE);
      if (!memop) begin
        wb_rd       = in_rd;
        wb_vd       = in_vd;
        wb_w_enable = in_w_enable;
      end else if (is_load && (state_q == S_DONE)) begin
        wb_rd       = in_rd;
        wb_vd       = load_val;
        wb_w_enable = in_w_enable;
      end
    end
  end

endmodule
